// File: rtl/uart_pkg.sv
// Shared UART constants and state encoding, used by the transmitter and the future receiver.
package uart_pkg;

  localparam int UART_DATA_WIDTH = 8;
  localparam int UART_BAUD_DIV   = 434;
  localparam int UART_CNT_WIDTH  = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/uart_tx_serializer_if.sv
// Holding-register side of the UART transmitter: byte and request in, status and serial line out.
interface uart_tx_serializer_if #(
  parameter int DATA_WIDTH = uart_pkg::UART_DATA_WIDTH
);

  logic [DATA_WIDTH-1:0] tx_data;
  logic                  tx_start;
  logic                  tx_busy;
  logic                  tx_done;
  logic                  tx;

  modport master (
    output tx_data,
    output tx_start,
    input  tx_busy,
    input  tx_done,
    input  tx
  );

  modport slave (
    input  tx_data,
    input  tx_start,
    output tx_busy,
    output tx_done,
    output tx
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: counts 0..BAUD_DIV-1 and wraps; tick marks the last cycle of each period.
// Synchronous clear holds the count at zero.
module uart_baud_cnt #(
  parameter int BAUD_DIV  = uart_pkg::UART_BAUD_DIV,
  parameter int CNT_WIDTH = uart_pkg::UART_CNT_WIDTH
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BAUD_DIV - 1);

  logic [CNT_WIDTH-1:0] count_q;
  logic [CNT_WIDTH-1:0] count_d;

  assign tick = (count_q == LAST_CNT);

  always_comb begin
    count_d = count_q + 1'b1;
    if (clear || tick) begin
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_tx_serializer.sv
// 8N1 UART transmitter: latches a byte on tx_start in IDLE and shifts it out LSB first.
// tx and tx_busy are registered from the next state so the line changes the cycle after acceptance.
module uart_tx_serializer
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = UART_DATA_WIDTH,
  parameter int BAUD_DIV   = UART_BAUD_DIV,
  parameter int CNT_WIDTH  = UART_CNT_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  uart_tx_serializer_if.slave  bus
);

  localparam int                IDX_W    = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DATA_WIDTH - 1);

  uart_state_e           state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [IDX_W-1:0]      bit_idx_q, bit_idx_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  tick;
  logic                  baud_clear;

  // Counter sits at zero while idle, so acceptance always starts a full start bit.
  assign baud_clear = (state_q == ST_IDLE);

  uart_baud_cnt #(
    .BAUD_DIV  (BAUD_DIV),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_baud_cnt (
    .clk   (clk),
    .rst   (rst),
    .clear (baud_clear),
    .tick  (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.tx_start) begin
          shift_d = bus.tx_data;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          bit_idx_d = '0;
          state_d   = ST_DATA;
        end
      end
      ST_DATA: begin
        if (tick) begin
          shift_d = shift_q >> 1;
          if (bit_idx_q == LAST_IDX) begin
            state_d = ST_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 1'b1;
          end
        end
      end
      ST_STOP: begin
        if (tick) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Line level is derived from where the FSM is heading, keeping tx a clean register.
    case (state_d)
      ST_START: tx_d = 1'b0;
      ST_DATA:  tx_d = shift_d[0];
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      tx_q      <= tx_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.tx      = tx_q;
  assign bus.tx_busy = busy_q;
  assign bus.tx_done = (state_q == ST_STOP) && tick;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Cycle-by-cycle check of uart_tx_serializer against a frame-waveform reference model.
module tb_uart_tx_serializer;

  localparam int DW = 8;
  localparam int BD = 4;
  localparam int FL = (DW + 2) * BD;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  uart_tx_serializer_if #(.DATA_WIDTH(DW)) bus ();

  uart_tx_serializer #(
    .DATA_WIDTH (DW),
    .BAUD_DIV   (BD),
    .CNT_WIDTH  (16)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model: an accepted byte becomes a precomputed line waveform played back one sample per cycle.
  bit wave [FL];
  bit active = 1'b0;
  int pos    = 0;
  int model_done_cnt = 0;
  int dut_done_cnt   = 0;
  int frames_started = 0;

  task automatic build_wave(input logic [DW-1:0] d);
    for (int k = 0; k < FL; k++) begin
      int b;
      b = k / BD;
      if (b == 0)       wave[k] = 1'b0;
      else if (b <= DW) wave[k] = d[b-1];
      else              wave[k] = 1'b1;
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s t=%0t got=%b exp=%b", tag, $time, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s t=%0t got=%0d exp=%0d", tag, $time, got, exp);
    end
  endtask

  // Drive inputs, take one clock edge, advance the model, compare all outputs.
  task automatic step(input logic r, input logic s, input logic [DW-1:0] d);
    logic exp_tx, exp_busy, exp_done;
    rst          = r;
    bus.tx_start = s;
    bus.tx_data  = d;
    @(posedge clk);
    #1;
    if (r) begin
      active = 1'b0;
      pos    = 0;
    end else if (active) begin
      pos++;
      if (pos == FL) begin
        active = 1'b0;
        pos    = 0;
      end
    end else if (s) begin
      build_wave(d);
      active = 1'b1;
      pos    = 0;
      frames_started++;
    end
    exp_tx   = active ? wave[pos] : 1'b1;
    exp_busy = active;
    exp_done = active && (pos == FL - 1);
    if (exp_done) model_done_cnt++;
    if (bus.tx_done === 1'b1) dut_done_cnt++;
    check_bit("tx", bus.tx, exp_tx);
    check_bit("tx_busy", bus.tx_busy, exp_busy);
    check_bit("tx_done", bus.tx_done, exp_done);
  endtask

  initial begin
    logic [DW-1:0] rd;
    bus.tx_start = 1'b0;
    bus.tx_data  = '0;

    // Reset, then a quiet idle line.
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b0, 8'h00);
    repeat (20) step(1'b0, 1'b0, 8'h00);

    // Single 0xA5 frame from a one-cycle request.
    step(1'b0, 1'b1, 8'hA5);
    repeat (FL + 5) step(1'b0, 1'b0, 8'h5A);
    check_int("a5_done_pulses", dut_done_cnt, 1);

    // Request held high: back-to-back frames with a one-cycle gap.
    repeat (2 * FL + 1) step(1'b0, 1'b1, 8'h00);
    repeat (6) step(1'b0, 1'b0, 8'h00);
    check_int("b2b_done_pulses", dut_done_cnt, model_done_cnt);

    // 0xFF frame with a new request and new data mid-frame.
    step(1'b0, 1'b1, 8'hFF);
    repeat (9) step(1'b0, 1'b0, 8'hFF);
    step(1'b0, 1'b1, 8'h00);
    repeat (FL + 8) step(1'b0, 1'b0, 8'h00);
    check_int("ff_done_pulses", dut_done_cnt, model_done_cnt);

    // Reset mid-frame at cycle 18 of a 0x3C frame, then a clean frame.
    step(1'b0, 1'b1, 8'h3C);
    repeat (17) step(1'b0, 1'b0, 8'h3C);
    step(1'b1, 1'b0, 8'h3C);
    repeat (3) step(1'b0, 1'b0, 8'h3C);
    check_int("rst_no_done", dut_done_cnt, model_done_cnt);
    step(1'b0, 1'b1, 8'hC3);
    repeat (FL + 3) step(1'b0, 1'b0, 8'h00);

    // LSB-first ordering.
    step(1'b0, 1'b1, 8'h01);
    repeat (FL + 3) step(1'b0, 1'b0, 8'h00);

    // Random requests and data churn.
    for (int i = 0; i < 600; i++) begin
      rd = DW'($urandom);
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 5) == 0), rd);
    end
    repeat (FL + 2) step(1'b0, 1'b0, 8'h00);
    check_int("rand_done_pulses", dut_done_cnt, model_done_cnt);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit end of the processor's memory-mapped serial port.
- Takes a parallel byte that the CPU has already written into the TX holding register, then shifts it out as an 8N1 UART frame on a single line.
- Reports busy/done back to the status register so software can poll before writing the next byte.
- Sits between the peripheral holding register and the board TX pin.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (LSB first).
- BAUD_DIV, 434, clock cycles per bit period (50 MHz / 115200). Legal range is 2 or more.
- CNT_WIDTH, 16, width of the bit-period counter; must hold BAUD_DIV-1.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
- tx_data  input  DATA_WIDTH  byte to send, taken from the holding register output.
- tx_start  input  1  request to send; level-sampled, only acted on in IDLE.
- tx_busy  output  1  high from the cycle after acceptance through the last stop-bit cycle.
- tx_done  output  1  one-cycle pulse in the last clock of the stop bit.
- tx  output  1  serial line, registered, idle high.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, tx=1, tx_busy=0, tx_done=0, counters=0, shift register=0. This applies at any point, including mid-frame; the next cycle shows tx=1.
- States: IDLE, START, DATA, STOP. Encoding is 2-bit binary; any undefined code returns to IDLE.
- IDLE:
  - tx=1, tx_busy=0.
  - If tx_start=1 at an edge: latch tx_data into the shift register, clear the baud counter, go to START.
  - tx_data is not sampled again for this frame.
- START:
  - tx=0 for exactly BAUD_DIV cycles.
  - When the baud counter reaches BAUD_DIV-1: clear it, set bit index=0, go to DATA.
- DATA:
  - tx = shift register bit 0.
  - At each baud counter wrap (BAUD_DIV-1): shift right by 1 and increment the bit index.
  - After bit DATA_WIDTH-1 completes, go to STOP.
- STOP:
  - tx=1 for BAUD_DIV cycles.
  - tx_done=1 during the final cycle (counter=BAUD_DIV-1), then go to IDLE.
- Latency:
  - tx falls in the cycle after the edge that samples tx_start.
  - Full frame is (DATA_WIDTH+2)*BAUD_DIV cycles.
  - tx_busy rises together with tx=0.
- tx_busy is registered and equals (state != IDLE).
- tx_start while busy, including the tx_done cycle, is ignored and not queued. The earliest next acceptance is the first IDLE cycle, giving back-to-back frames with a one-cycle idle gap.
- Changing tx_data after acceptance has no effect on the frame in flight.
- Counters never exceed BAUD_DIV-1; the bit index never exceeds DATA_WIDTH-1.
- No parity, single stop bit, no flow control.

Decomposition:
- Shared package uart_pkg holds:
  - state encoding constants: ST_IDLE=2'd0, ST_START=2'd1, ST_DATA=2'd2, ST_STOP=2'd3;
  - default BAUD_DIV and DATA_WIDTH constants, reused by the future receiver.
- One sub-module, uart_baud_cnt, handles bit-period timing:
  - parameters BAUD_DIV and CNT_WIDTH;
  - inputs clk, rst, clear;
  - output tick, high when count=BAUD_DIV-1;
  - synchronous clear;
  - reused later by the receiver.
- The FSM and shift register stay in the top module.

Test Plan (BAUD_DIV=4, DATA_WIDTH=8 in simulation):
- Reset, then hold idle 20 cycles -> tx=1, tx_busy=0, tx_done=0 throughout.
- tx_data=8'hA5, one-cycle tx_start -> tx low for cycles 1-4, then bits 1,0,1,0,0,1,0,1 each 4 cycles, then high for 4 cycles. tx_done pulses once at cycle 40, tx_busy is high for cycles 1-40, and the total frame is 40 cycles.
- tx_start held high continuously with tx_data=8'h00 -> two frames separated by exactly one idle cycle (tx=1, tx_busy=0). Each frame shows 9 low bit periods followed by 1 high stop period.
- During a frame with 8'hFF, pulse tx_start and change tx_data to 8'h00 at cycle 10 -> frame still carries 8'hFF, no extra frame follows, and tx_done pulses exactly once.
- Assert rst at cycle 18 of an 8'h3C frame -> next cycle tx=1 and tx_busy=0, with no tx_done. A new tx_start afterward produces a clean 40-cycle frame.
- tx_data=8'h01 -> first data bit period is high and the remaining seven are low, confirming LSB-first order.
